checkpoint_unit: RTL
====================

Name: checkpoint_unit

Overview:
- Writer side of the fault-recovery shadow state. The recovery controller only reads it: it replays a register address and writes the shadow PC and GPRs back into the core.
- This block periodically stalls the core, sweeps its PC and GPR file into a double-buffered shadow store, and commits the copy atomically.
- It serves the last good checkpoint on a combinational replay read port.
- An error mid-capture discards the partial copy and never corrupts the committed bank.

Parameters:
ADDR_WIDTH, 5, GPR address width; NUM_REG = 2**ADDR_WIDTH
DATA_WIDTH, 32, GPR/PC width
PERIOD, 1024, idle cycles between automatic checkpoints (>=2)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
error_i  input  1  fault detected; aborts capture, freezes store
resume_i  input  1  recovery finished pulse; releases HOLD
ckpt_req_i  input  1  force a checkpoint now (single-cycle pulse)
stall_o  output  1  request core stall for capture
core_rdy_i  input  1  core stalled and quiescent (ack to stall_o)
core_pc_i  input  DATA_WIDTH  core PC
core_raddr_o  output  ADDR_WIDTH  core GPR read address
core_rdata_i  input  DATA_WIDTH  GPR data, valid one cycle after core_raddr_o
valid_o  output  1  a committed checkpoint exists
replay_addr_i  input  ADDR_WIDTH  replay read address
replay_gpr_o  output  DATA_WIDTH  committed GPR[replay_addr_i], combinational
replay_pc_o  output  DATA_WIDTH  committed PC, combinational

Behaviour:
- Reset (async, rst_ni=0) values:
  - state IDLE, timer 0, good_bank 0, both banks 0.
  - stall_o 0, core_raddr_o 0, valid_o 0.
- States: IDLE, WAIT_RDY, SWEEP, COMMIT, HOLD.
- IDLE:
  - Timer increments each cycle.
  - On timer==PERIOD-1 or ckpt_req_i: clear timer and go to WAIT_RDY.
- WAIT_RDY:
  - stall_o=1.
  - On core_rdy_i=1: write core_pc_i into the capture bank (!good_bank), set core_raddr_o=0, go to SWEEP.
  - core_rdy_i is sampled only in this state; the core must stay stalled while stall_o=1.
- SWEEP:
  - stall_o=1. core_raddr_o takes 0..NUM_REG-1 on consecutive cycles.
  - core_rdata_i is written to capture bank entry core_raddr_o-of-previous-cycle.
  - After address NUM_REG-1 is issued, go to COMMIT.
- COMMIT (one cycle):
  - Write the final entry (NUM_REG-1).
  - Toggle good_bank, set valid_o=1, stall_o=0, go to IDLE.
- Capture latency: core_rdy_i accept to stall_o deassert = NUM_REG+1 cycles (33 at default). New data is visible on replay ports the cycle after COMMIT.
- Error handling:
  - error_i=1 in any state has top priority: go to HOLD, stall_o=0, timer cleared.
  - In COMMIT, no toggle occurs, so the partial capture is discarded.
  - Replay reads always use good_bank.
- HOLD:
  - Ignores ckpt_req_i and the timer.
  - Leaves on resume_i=1 with error_i=0, to IDLE.
  - resume_i in any other state is ignored.
- Simultaneous events:
  - error_i beats ckpt_req_i and beats timer expiry.
  - ckpt_req_i outside IDLE is ignored, not queued.
- Replay ports: valid_o=0 forces replay_gpr_o=0 and replay_pc_o=0. Reading is allowed in every state, with no side effects.
- Async reset mid-capture: return to reset values immediately; all checkpoints are lost.

Test Plan:
- Reset, PERIOD=16, core_rdy_i tied 1 → stall_o rises after 16 idle cycles and stays high 33 cycles. Then valid_o=1 and replay_pc_o=core_pc_i sampled at accept. GPR k=0x1000+k returns replay_gpr_o[k]=0x1000+k for all 32 k.
- Second checkpoint with GPR k=0x2000+k → during the sweep replay still returns 0x1000+k; after COMMIT it returns 0x2000+k.
- error_i pulse at SWEEP address 10 → stall_o drops next cycle, state HOLD, replay returns 0x1000+k. ckpt_req_i is ignored until resume_i, then the next checkpoint completes normally.
- error_i in the COMMIT cycle → valid bank unchanged, replay_pc_o holds the old PC.
- ckpt_req_i with core_rdy_i=0 for 7 cycles → stall_o high, core_raddr_o stays 0, sweep starts on the rdy cycle. A second ckpt_req_i during the sweep produces no extra capture.
- Before any checkpoint, replay_addr_i=5 → replay_gpr_o=0, replay_pc_o=0, valid_o=0. rst_ni low mid-sweep → all outputs reset at once.

Source files
------------

// File: rtl/checkpoint_unit.sv
// -----------------------------------------------------------------------------
// checkpoint_unit
//
// Purpose:
//   Writer side of the fault-recovery shadow state. Periodically (or on
//   request) stalls the core, sweeps its PC and GPR file into the inactive
//   half of a double-buffered shadow store, then flips the active half in a
//   single cycle so the committed checkpoint changes atomically. The last
//   good checkpoint is served on a combinational replay read port. A fault
//   during capture discards the partial copy and parks the unit in HOLD
//   until the recovery controller signals resume.
//
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   error_i        fault detected; aborts capture, freezes store (top priority)
//   resume_i       recovery finished pulse; leaves HOLD
//   ckpt_req_i     force a checkpoint now (ignored outside IDLE)
//   stall_o        stall request to the core while capturing
//   core_rdy_i     core stalled and quiescent (ack to stall_o)
//   core_pc_i      core PC, captured on the accept cycle
//   core_raddr_o   core GPR read address during the sweep
//   core_rdata_i   GPR data, valid one cycle after core_raddr_o
//   valid_o        a committed checkpoint exists
//   replay_addr_i  replay read address
//   replay_gpr_o   committed GPR[replay_addr_i] (0 while nothing committed)
//   replay_pc_o    committed PC (0 while nothing committed)
//
// Handshake: stall_o is a request held high from WAIT_RDY through SWEEP;
// core_rdy_i is its acknowledge, sampled only in WAIT_RDY. Once acknowledged
// the core must remain stalled until stall_o falls.
// -----------------------------------------------------------------------------
module checkpoint_unit #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int PERIOD     = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  error_i,
    input  logic                  resume_i,
    input  logic                  ckpt_req_i,
    output logic                  stall_o,
    input  logic                  core_rdy_i,
    input  logic [DATA_WIDTH-1:0] core_pc_i,
    output logic [ADDR_WIDTH-1:0] core_raddr_o,
    input  logic [DATA_WIDTH-1:0] core_rdata_i,
    output logic                  valid_o,
    input  logic [ADDR_WIDTH-1:0] replay_addr_i,
    output logic [DATA_WIDTH-1:0] replay_gpr_o,
    output logic [DATA_WIDTH-1:0] replay_pc_o
);

    localparam int NUM_REG = 2 ** ADDR_WIDTH;
    localparam int TIMER_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_REG - 1);
    localparam logic [TIMER_W-1:0]    TIMER_LAST = TIMER_W'(PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_SWEEP    = 3'd2,
        S_COMMIT   = 3'd3,
        S_HOLD     = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic                  good_bank_q;
    logic                  valid_q;

    logic [DATA_WIDTH-1:0] gpr_bank_q [2][NUM_REG];
    logic [DATA_WIDTH-1:0] pc_bank_q  [2];

    // Decoded strobes from the output process
    logic                  pc_we;
    logic                  gpr_we;
    logic [ADDR_WIDTH-1:0] gpr_waddr;
    logic                  commit_en;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. error_i overrides everything else.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (error_i) begin
            state_d = S_HOLD;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ckpt_req_i || (timer_q == TIMER_LAST)) begin
                        state_d = S_WAIT_RDY;
                    end
                end
                S_WAIT_RDY: begin
                    if (core_rdy_i) begin
                        state_d = S_SWEEP;
                    end
                end
                S_SWEEP: begin
                    if (raddr_q == LAST_ADDR) begin
                        state_d = S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    state_d = S_IDLE;
                end
                S_HOLD: begin
                    if (resume_i) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs and datapath strobes
    // ------------------------------------------------------------------
    always_comb begin
        stall_o   = 1'b0;
        pc_we     = 1'b0;
        gpr_we    = 1'b0;
        gpr_waddr = '0;
        commit_en = 1'b0;
        case (state_q)
            S_WAIT_RDY: begin
                stall_o = 1'b1;
                pc_we   = core_rdy_i && !error_i;
            end
            S_SWEEP: begin
                stall_o = 1'b1;
                // Read data lags the address by one cycle, so the first
                // sweep cycle (address 0) has nothing to store yet.
                gpr_we    = (raddr_q != '0) && !error_i;
                gpr_waddr = raddr_q - ADDR_WIDTH'(1);
            end
            S_COMMIT: begin
                gpr_we    = !error_i;
                gpr_waddr = LAST_ADDR;
                commit_en = !error_i;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Timer and sweep address
    // ------------------------------------------------------------------
    always_comb begin
        timer_d = '0;
        if ((state_q == S_IDLE) && (state_d == S_IDLE)) begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    always_comb begin
        raddr_d = '0;
        if ((state_q == S_SWEEP) && !error_i && (raddr_q != LAST_ADDR)) begin
            raddr_d = raddr_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_q <= '0;
            raddr_q <= '0;
        end else begin
            timer_q <= timer_d;
            raddr_q <= raddr_d;
        end
    end

    // ------------------------------------------------------------------
    // Shadow store. Captures always target the inactive bank; the commit
    // flips good_bank_q, which is what makes the update atomic.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            good_bank_q <= 1'b0;
            valid_q     <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                pc_bank_q[b] <= '0;
                for (int r = 0; r < NUM_REG; r++) begin
                    gpr_bank_q[b][r] <= '0;
                end
            end
        end else begin
            if (pc_we) begin
                pc_bank_q[!good_bank_q] <= core_pc_i;
            end
            if (gpr_we) begin
                gpr_bank_q[!good_bank_q][gpr_waddr] <= core_rdata_i;
            end
            if (commit_en) begin
                good_bank_q <= !good_bank_q;
                valid_q     <= 1'b1;
            end
        end
    end

    assign core_raddr_o = raddr_q;
    assign valid_o      = valid_q;
    assign replay_gpr_o = valid_q ? gpr_bank_q[good_bank_q][replay_addr_i] : '0;
    assign replay_pc_o  = valid_q ? pc_bank_q[good_bank_q] : '0;

endmodule
